// File: rtl/bcd_counter_n.sv
// N-digit packed-BCD up/down counter with checked parallel load.
// Wrap pulse cascades to downstream counters; ovf is sticky until clr.
module bcd_counter_n #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Din,
    input  logic                  en,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   Q_out,
    output logic                  wrap,
    output logic                  ovf,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]      q_inc;
    logic [W-1:0]      q_dec;
    logic [DIGITS:0]   cy;
    logic [DIGITS:0]   bw;
    logic [DIGITS-1:0] dig_ok;
    logic              din_ok;

    logic [W-1:0]      q_nxt;
    logic              wrap_nxt;
    logic              ovf_nxt;
    logic              err_nxt;

    assign cy[0] = 1'b1;
    assign bw[0] = 1'b1;

    // Ripple enable: a digit steps only when every lower digit is at its limit.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
        logic [3:0] d;
        logic [3:0] l;

        assign d = Q_out[4*gi +: 4];
        assign l = Din[4*gi +: 4];

        assign cy[gi+1] = cy[gi] & (d == 4'd9);
        assign bw[gi+1] = bw[gi] & (d == 4'd0);

        assign q_inc[4*gi +: 4] = !cy[gi]     ? d     :
                                  (d == 4'd9) ? 4'd0  :
                                                d + 4'd1;

        assign q_dec[4*gi +: 4] = !bw[gi]     ? d     :
                                  (d == 4'd0) ? 4'd9  :
                                                d - 4'd1;

        assign dig_ok[gi] = (l <= 4'd9);
    end

    assign din_ok = &dig_ok;

    always_comb begin
        q_nxt    = Q_out;
        wrap_nxt = 1'b0;
        ovf_nxt  = ovf;
        err_nxt  = 1'b0;
        if (clr) begin
            q_nxt   = '0;
            ovf_nxt = 1'b0;
        end else if (Load) begin
            if (din_ok) begin
                q_nxt = Din;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                q_nxt    = q_inc;
                wrap_nxt = cy[DIGITS];
            end else begin
                q_nxt    = q_dec;
                wrap_nxt = bw[DIGITS];
            end
            ovf_nxt = ovf | wrap_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q_out    <= '0;
            wrap     <= 1'b0;
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else begin
            Q_out    <= q_nxt;
            wrap     <= wrap_nxt;
            ovf      <= ovf_nxt;
            load_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n: 2-digit and 4-digit instances.
// Expected values are hand-computed constants or decimal-to-BCD conversion.
module tb_bcd_counter_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        clr2 = 1'b0, load2 = 1'b0, en2 = 1'b0, up2 = 1'b1;
    logic [7:0]  din2 = '0;
    logic [7:0]  q2;
    logic        wrap2, ovf2, err2;

    logic        clr4 = 1'b0, load4 = 1'b0, en4 = 1'b0, up4 = 1'b1;
    logic [15:0] din4 = '0;
    logic [15:0] q4;
    logic        wrap4, ovf4, err4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_counter_n #(.DIGITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr2), .Load(load2), .Din(din2),
        .en(en2), .up(up2), .Q_out(q2), .wrap(wrap2), .ovf(ovf2),
        .load_err(err2)
    );

    bcd_counter_n #(.DIGITS(4)) u4 (
        .clk(clk), .rst_n(rst_n), .clr(clr4), .Load(load4), .Din(din4),
        .en(en4), .up(up4), .Q_out(q4), .wrap(wrap4), .ovf(ovf4),
        .load_err(err4)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] bcd2(input int n);
        return 16'((n / 10) * 16 + (n % 10));
    endfunction

    logic [7:0] dn_exp [6];

    initial begin
        dn_exp = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h99};

        // reset state
        #3;
        chk("rst_q", 16'(q2), 16'h00);
        chk("rst_wrap", 16'(wrap2), 16'h0);
        chk("rst_ovf", 16'(ovf2), 16'h0);
        chk("rst_err", 16'(err2), 16'h0);
        #7 rst_n = 1'b1;

        // full up-count 00..99,00
        en2 = 1'b1;
        up2 = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            chk("up_q", 16'(q2), bcd2(i % 100));
            chk("up_wrap", 16'(wrap2), 16'(i == 100));
            chk("up_ovf", 16'(ovf2), 16'(i == 100));
        end

        // load 05 then count down through 00 to 99
        en2 = 1'b0;
        load2 = 1'b1;
        din2 = 8'h05;
        step();
        chk("ld05_q", 16'(q2), 16'h05);
        chk("ld05_ovf", 16'(ovf2), 16'h1);
        chk("ld05_err", 16'(err2), 16'h0);
        load2 = 1'b0;
        en2 = 1'b1;
        up2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("dn_q", 16'(q2), 16'(dn_exp[i]));
            chk("dn_wrap", 16'(wrap2), 16'(i == 5));
            chk("dn_err", 16'(err2), 16'h0);
        end

        // rejected loads
        en2 = 1'b0;
        load2 = 1'b1;
        din2 = 8'h37;
        step();
        chk("ld37_q", 16'(q2), 16'h37);
        din2 = 8'h5A;
        step();
        chk("bad5A_q", 16'(q2), 16'h37);
        chk("bad5A_err", 16'(err2), 16'h1);
        load2 = 1'b0;
        step();
        chk("err_clr", 16'(err2), 16'h0);
        chk("bad_hold", 16'(q2), 16'h37);
        load2 = 1'b1;
        din2 = 8'hA3;
        step();
        chk("badA3_q", 16'(q2), 16'h37);
        chk("badA3_err", 16'(err2), 16'h1);
        din2 = 8'h42;
        step();
        chk("ld42_q", 16'(q2), 16'h42);
        chk("ld42_err", 16'(err2), 16'h0);

        // clr beats Load and en
        din2 = 8'h99;
        step();
        chk("ld99_q", 16'(q2), 16'h99);
        chk("ld99_ovf", 16'(ovf2), 16'h1);
        clr2 = 1'b1;
        en2 = 1'b1;
        up2 = 1'b1;
        din2 = 8'h55;
        step();
        chk("clr_q", 16'(q2), 16'h00);
        chk("clr_ovf", 16'(ovf2), 16'h0);
        chk("clr_wrap", 16'(wrap2), 16'h0);
        clr2 = 1'b0;

        // Load beats en
        din2 = 8'h50;
        step();
        chk("ld50_q", 16'(q2), 16'h50);
        chk("ld50_wrap", 16'(wrap2), 16'h0);

        // hold, then direction toggling
        din2 = 8'h19;
        step();
        load2 = 1'b0;
        en2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_q", 16'(q2), 16'h19);
        end
        en2 = 1'b1;
        up2 = 1'b1; step(); chk("tog1", 16'(q2), 16'h20);
        up2 = 1'b0; step(); chk("tog2", 16'(q2), 16'h19);
        up2 = 1'b1; step(); chk("tog3", 16'(q2), 16'h20);
        up2 = 1'b0; step(); chk("tog4", 16'(q2), 16'h19);
        chk("tog_ovf", 16'(ovf2), 16'h0);

        // async reset between edges, also during a load
        up2 = 1'b1;
        step();
        chk("pre_rst", 16'(q2), 16'h20);
        load2 = 1'b1;
        din2 = 8'h77;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q", 16'(q2), 16'h00);
        step();
        chk("arst_hold", 16'(q2), 16'h00);
        load2 = 1'b0;
        en2 = 1'b0;
        #2 rst_n = 1'b1;
        step();
        chk("arst_rel", 16'(q2), 16'h00);

        // 4-digit instance
        load4 = 1'b1;
        din4 = 16'h9999;
        step();
        chk("d4_ld", q4, 16'h9999);
        load4 = 1'b0;
        en4 = 1'b1;
        up4 = 1'b1;
        step();
        chk("d4_wrap_q", q4, 16'h0000);
        chk("d4_wrap", 16'(wrap4), 16'h1);
        chk("d4_ovf", 16'(ovf4), 16'h1);
        up4 = 1'b0;
        step();
        chk("d4_dn_q", q4, 16'h9999);
        chk("d4_dn_wrap", 16'(wrap4), 16'h1);
        en4 = 1'b0;
        load4 = 1'b1;
        din4 = 16'h0999;
        step();
        load4 = 1'b0;
        en4 = 1'b1;
        up4 = 1'b1;
        step();
        chk("d4_ripple", q4, 16'h1000);
        chk("d4_rip_wrap", 16'(wrap4), 16'h0);
        up4 = 1'b0;
        step();
        chk("d4_borrow", q4, 16'h0999);
        en4 = 1'b0;
        load4 = 1'b1;
        din4 = 16'h12F4;
        step();
        chk("d4_bad_q", q4, 16'h0999);
        chk("d4_bad_err", 16'(err4), 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
Parametrised N-digit BCD up/down counter. It generalises the team's 2-digit load-and-count BCD block with the following additions:
- configurable digit count
- full-width parallel load with BCD validity checking
- count enable and direction control
- synchronous clear
- wrap (carry/borrow) pulse and a sticky overflow flag

It sits in the display and timebase path, feeding 7-segment decoders and cascading to other counters through the wrap pulse.

Parameters:
DIGITS, 2, number of BCD digits (1..8); count range 0 .. 10^DIGITS-1
W, 4*DIGITS, derived, data width (not overridable)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear, highest synchronous priority
Load  in  1  synchronous parallel load of Din
Din  in  W  load value; digit k in bits [4k+3:4k], digit 0 = least significant
en  in  1  count enable
up  in  1  direction: 1 = increment, 0 = decrement
Q_out  out  W  current count, packed BCD, same digit order as Din
wrap  out  1  one-cycle pulse on roll-over (up) or roll-under (down)
ovf  out  1  sticky flag, set by any wrap
load_err  out  1  one-cycle pulse: Load rejected because Din held an invalid digit

Behaviour:
- Clock, reset and registers:
  - One clock domain.
  - rst_n low asynchronously forces Q_out=0, wrap=0, ovf=0, load_err=0 and holds them while low.
  - Release is synchronous to the next rising edge.
  - All outputs are registered; none is combinational from inputs.
- Priority on each rising edge: clr > Load > en. Inputs with lower priority are ignored in that cycle.
- clr=1:
  - Q_out<=0, ovf<=0, wrap<=0, load_err<=0.
- Load=1, clr=0:
  - If every Din digit is <=9: Q_out<=Din next edge (1-cycle latency), load_err<=0, wrap<=0, ovf unchanged.
  - If any Din digit is >9 (A..F): Q_out unchanged, load_err<=1 for exactly one cycle, wrap<=0.
  - Load is never partial.
- en=1, clr=0, Load=0, up=1:
  - Digit 0 increments.
  - Each digit k>0 increments only when all lower digits equal 9.
  - A digit equal to 9 that increments becomes 0.
  - All-9s -> all-0s; wrap<=1 for that cycle only; ovf<=1.
- en=1, clr=0, Load=0, up=0:
  - Digit 0 decrements.
  - Each digit k>0 decrements only when all lower digits equal 0.
  - A digit equal to 0 that decrements becomes 9.
  - All-0s -> all-9s; wrap<=1; ovf<=1.
- en=0, clr=0, Load=0:
  - Q_out holds; wrap<=0; load_err<=0; ovf holds.
- Timing of wrap:
  - wrap is asserted in the same cycle Q_out first shows the wrapped value.
  - Cascading: a downstream counter's en tied to this wrap advances one cycle after the wrap edge.
- Direction change:
  - up may change on any cycle and takes effect on the next enabled edge.
  - There is no hidden state beyond Q_out and ovf.
- ovf:
  - Stays 1 until clr or reset.
  - Load does not clear ovf.
- Arithmetic:
  - Per-digit 4-bit BCD with ripple enable between digits.
  - Q_out never holds a digit >9 under any input sequence.
  - DIGITS=1 is legal and wraps 9<->0.
- Reset mid-operation: rst_n low during counting or during a Load cycle aborts immediately to the reset values; no load completes.

Test Plan:
- DIGITS=2. Reset with rst_n=0 for 10ns then release; en=1, up=1 for 100 edges -> Q_out steps 8'h00,01..09,10..99,00. wrap=1 only in the cycle Q_out=8'h00 after 8'h99. ovf=1 from that cycle on.
- Load=1 with Din=8'h05 for one cycle, then en=1, up=0 -> Q_out=8'h05,04..00,99. wrap pulses once at 8'h99. load_err stays 0.
- Load=1 with Din=8'h5A while Q_out=8'h37 -> Q_out stays 8'h37; load_err=1 for exactly one cycle; then Din=8'h42 loads 8'h42.
- Simultaneous events:
  - clr=1, Load=1, en=1 with Q_out=8'h99 and ovf=1 -> Q_out=8'h00, ovf=0, wrap=0.
  - Load=1 with en=1 and Din=8'h50 -> Q_out=8'h50, not 8'h51.
- Hold and direction: en=0 for 5 cycles at 8'h19 -> Q_out holds 8'h19. Then toggle up every cycle with en=1 -> 8'h20,19,20,19.
- Asynchronous reset and DIGITS=4:
  - Assert rst_n=0 mid-count between clock edges -> Q_out=0 immediately, before the next edge.
  - DIGITS=4 instance with Din=16'h9999 loaded, then increment -> 16'h0000 with wrap=1.
